// File: rtl/fc2_timestep_ctrl_pkg.sv
// Shared types and constants for the FC2 timestep controller and its argmax scanner.
package fc2_ctrl_pkg;

    localparam int DEF_INPUT_NODES  = 20;
    localparam int DEF_OUTPUT_NODES = 10;
    localparam int DEF_T_STEPS      = 4;
    localparam int DEF_SETTLE       = 6;

    // Width of the class index reported to the outside world.
    localparam int CLASS_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_IN,
        FEED,
        SETTLE_W,
        SAMPLE,
        DECIDE,
        DONE
    } fc2_ctrl_state_t;

endpackage

// File: rtl/fc2_timestep_ctrl_if.sv
// Spike-vector handshake plus the serial feed and spike return path of the FC2 datapath.
// The master side produces layer-1 vectors and LIF2 spikes; the slave side is the controller.
interface fc2_timestep_ctrl_if #(
    parameter int INPUT_NODES  = 20,
    parameter int OUTPUT_NODES = 10
) ();

    logic [INPUT_NODES-1:0]  spk1_vec;
    logic                    spk1_valid;
    logic                    spk1_ready;
    logic                    fc_addra_valid;
    logic                    input_fc_array;
    logic [OUTPUT_NODES-1:0] spk_2;

    modport master (
        output spk1_vec,
        output spk1_valid,
        output spk_2,
        input  spk1_ready,
        input  fc_addra_valid,
        input  input_fc_array
    );

    modport slave (
        input  spk1_vec,
        input  spk1_valid,
        input  spk_2,
        output spk1_ready,
        output fc_addra_valid,
        output input_fc_array
    );

endinterface

// File: rtl/fc2_argmax_scan.sv
// Sequential argmax over the per-class spike counters, one counter per cycle.
// The idx/max outputs already include the counter under inspection this cycle,
// so on the cycle valid is high they hold the final winner and can be registered directly.
module fc2_argmax_scan
    import fc2_ctrl_pkg::*;
#(
    parameter int N  = 10,
    parameter int CW = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 go,
    input  logic [N-1:0][CW-1:0] cnt,
    output logic [CLASS_W-1:0]   idx,
    output logic [CW-1:0]        max,
    output logic                 valid
);

    logic                 running;
    logic [CLASS_W-1:0]   pos;
    logic [CLASS_W-1:0]   best_idx;
    logic [CW-1:0]        best_val;
    logic [CW-1:0]        cur_val;
    logic                 take;

    // Compare the current counter against the best so far; only strictly greater wins,
    // so ties keep the lower index that was seen first.
    always_comb begin
        cur_val = cnt[pos];
        take    = running && (cur_val > best_val);
        idx     = take ? pos : best_idx;
        max     = take ? cur_val : best_val;
        valid   = running && (pos == CLASS_W'(N - 1));
    end

    // Walk the counters from index 0 upward after each go pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            running  <= 1'b0;
            pos      <= '0;
            best_idx <= '0;
            best_val <= '0;
        end else if (go) begin
            running  <= 1'b1;
            pos      <= '0;
            best_idx <= '0;
            best_val <= '0;
        end else if (running) begin
            best_idx <= idx;
            best_val <= max;
            if (valid) begin
                running <= 1'b0;
            end else begin
                pos <= pos + CLASS_W'(1);
            end
        end
    end

endmodule

// File: rtl/fc2_timestep_ctrl.sv
// Timestep sequencer for the FC2 + LIF2 output stage: serialises each layer-1 spike
// vector onto the datapath, waits for LIF2 to settle, accumulates output spikes per
// class and, after T_STEPS timesteps, reports the winning class.
module fc2_timestep_ctrl
    import fc2_ctrl_pkg::*;
#(
    parameter int INPUT_NODES  = DEF_INPUT_NODES,
    parameter int OUTPUT_NODES = DEF_OUTPUT_NODES,
    parameter int T_STEPS      = DEF_T_STEPS,
    parameter int SETTLE       = DEF_SETTLE,
    parameter int CW           = $clog2(T_STEPS + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    fc2_timestep_ctrl_if.slave   bus,
    output logic                 busy,
    output logic                 done,
    output logic [CLASS_W-1:0]   class_id,
    output logic [CW-1:0]        class_cnt
);

    localparam int IDX_W = $clog2(INPUT_NODES + 1);
    localparam int SET_W = $clog2(SETTLE + 1);

    fc2_ctrl_state_t                state;
    fc2_ctrl_state_t                state_next;
    logic [INPUT_NODES-1:0]         shreg;
    logic [IDX_W-1:0]               idx;
    logic [SET_W-1:0]               set_cnt;
    logic [CW-1:0]                  t;
    logic [OUTPUT_NODES-1:0][CW-1:0] cnt;
    logic                           last_step;
    logic                           scan_go;
    logic [CLASS_W-1:0]             scan_idx;
    logic [CW-1:0]                  scan_max;
    logic                           scan_valid;

    assign last_step = (t == CW'(T_STEPS - 1));
    assign scan_go   = (state == SAMPLE) && last_step;

    fc2_argmax_scan #(
        .N  (OUTPUT_NODES),
        .CW (CW)
    ) u_scan (
        .clk   (clk),
        .reset (reset),
        .go    (scan_go),
        .cnt   (cnt),
        .idx   (scan_idx),
        .max   (scan_max),
        .valid (scan_valid)
    );

    // State register; a reset drops any inference in flight straight back to IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and the state-derived handshake and datapath outputs.
    always_comb begin
        state_next         = state;
        bus.spk1_ready     = 1'b0;
        bus.fc_addra_valid = 1'b0;
        bus.input_fc_array = 1'b0;
        busy               = (state != IDLE);
        done               = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = WAIT_IN;
                end
            end
            WAIT_IN: begin
                bus.spk1_ready = 1'b1;
                if (bus.spk1_valid) begin
                    state_next = FEED;
                end
            end
            FEED: begin
                bus.fc_addra_valid = 1'b1;
                bus.input_fc_array = (idx < IDX_W'(INPUT_NODES)) ? shreg[0] : 1'b0;
                if (idx == IDX_W'(INPUT_NODES)) begin
                    state_next = SETTLE_W;
                end
            end
            SETTLE_W: begin
                if (set_cnt == SET_W'(SETTLE - 1)) begin
                    state_next = SAMPLE;
                end
            end
            SAMPLE: begin
                state_next = last_step ? DECIDE : WAIT_IN;
            end
            DECIDE: begin
                if (scan_valid) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Serialiser, settle timer, timestep counter and per-class spike accumulation.
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg   <= '0;
            idx     <= '0;
            set_cnt <= '0;
            t       <= '0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt <= '0;
                        t   <= '0;
                    end
                end
                WAIT_IN: begin
                    if (bus.spk1_valid) begin
                        shreg <= bus.spk1_vec;
                        idx   <= '0;
                    end
                end
                FEED: begin
                    shreg   <= shreg >> 1;
                    idx     <= idx + IDX_W'(1);
                    set_cnt <= '0;
                end
                SETTLE_W: begin
                    set_cnt <= set_cnt + SET_W'(1);
                end
                SAMPLE: begin
                    for (int k = 0; k < OUTPUT_NODES; k++) begin
                        cnt[k] <= cnt[k] + CW'(bus.spk_2[k]);
                    end
                    if (!last_step) begin
                        t <= t + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Capture the winner on the final scan cycle so it is visible alongside done.
    always_ff @(posedge clk) begin
        if (reset) begin
            class_id  <= '0;
            class_cnt <= '0;
        end else if (scan_valid) begin
            class_id  <= scan_idx;
            class_cnt <= scan_max;
        end
    end

endmodule

// File: tb/tb_fc2_timestep_ctrl.sv
// Directed self-checking bench for fc2_timestep_ctrl.
module tb_fc2_timestep_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       busy;
    logic       done;
    logic [3:0] class_id;
    logic [2:0] class_cnt;

    int checks = 0;
    int errors = 0;

    fc2_timestep_ctrl_if bus_if ();

    fc2_timestep_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .bus       (bus_if),
        .busy      (busy),
        .done      (done),
        .class_id  (class_id),
        .class_cnt (class_cnt)
    );

    always #5 clk = ~clk;

    // Hard stop in case something hangs outside the bounded waits.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // One timestep: handshake vec, record the 28 cycles of FEED/SETTLE/SAMPLE, end in cycle 29.
    task automatic apply_stimulus(input logic [19:0] vec, input logic [9:0] spk);
        int          budget;
        int          addr_cnt;
        logic [31:0] fed;
        budget   = 0;
        addr_cnt = 0;
        fed      = '0;
        bus_if.spk_2 = spk;
        while (!bus_if.spk1_ready && budget < 100) begin
            tick();
            budget++;
        end
        check_output("ready_wait", {31'b0, bus_if.spk1_ready}, 32'd1);
        if (!bus_if.spk1_ready) return;
        bus_if.spk1_vec   = vec;
        bus_if.spk1_valid = 1'b1;
        tick();
        bus_if.spk1_valid = 1'b0;
        for (int c = 1; c <= 28; c++) begin
            if (bus_if.fc_addra_valid) addr_cnt++;
            if (bus_if.input_fc_array) fed[c-1] = 1'b1;
            tick();
        end
        check_output("feed_bits", fed, {12'b0, vec});
        check_output("addra_cycles", 32'(addr_cnt), 32'd21);
    endtask

    // Called at the cycle after the final SAMPLE; expects done 11 cycles after that SAMPLE.
    task automatic wait_done(input logic [3:0] exp_id, input logic [2:0] exp_cnt, input bit poke_start);
        int         lat;
        int         pulses;
        logic [3:0] got_id;
        logic [2:0] got_cnt;
        lat     = 0;
        pulses  = 0;
        got_id  = '0;
        got_cnt = '0;
        for (int n = 1; n <= 20; n++) begin
            if (poke_start) start = (n == 3);
            if (done) begin
                pulses++;
                if (lat == 0) begin
                    lat     = n;
                    got_id  = class_id;
                    got_cnt = class_cnt;
                end
            end
            tick();
        end
        start = 1'b0;
        check_output("done_latency", 32'(lat), 32'd11);
        check_output("done_pulses", 32'(pulses), 32'd1);
        check_output("class_id", {28'b0, got_id}, {28'b0, exp_id});
        check_output("class_cnt", {29'b0, got_cnt}, {29'b0, exp_cnt});
        check_output("idle_after", {31'b0, busy}, 32'd0);
    endtask

    task automatic begin_inference();
        start = 1'b1;
        tick();
        start = 1'b0;
        check_output("busy_after_start", {31'b0, busy}, 32'd1);
    endtask

    initial begin
        bit bp_ok;
        reset             = 1'b1;
        start             = 1'b0;
        bus_if.spk1_vec   = '0;
        bus_if.spk1_valid = 1'b0;
        bus_if.spk_2      = '0;
        tick();
        tick();

        check_output("rst_ready", {31'b0, bus_if.spk1_ready}, 32'd0);
        check_output("rst_addra", {31'b0, bus_if.fc_addra_valid}, 32'd0);
        check_output("rst_fc_bit", {31'b0, bus_if.input_fc_array}, 32'd0);
        check_output("rst_busy", {31'b0, busy}, 32'd0);
        check_output("rst_done", {31'b0, done}, 32'd0);
        check_output("rst_class_id", {28'b0, class_id}, 32'd0);
        check_output("rst_class_cnt", {29'b0, class_cnt}, 32'd0);
        reset = 1'b0;
        tick();

        // Feed alignment and a clear winner (class 3, four spikes); start poked in WAIT_IN.
        begin_inference();
        apply_stimulus(20'h80001, 10'b0000001000);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_output("start_ignored_busy", {31'b0, bus_if.spk1_ready}, 32'd1);
        apply_stimulus(20'h00F00, 10'b0000001000);
        apply_stimulus(20'hAAAAA, 10'b0000001000);
        apply_stimulus(20'h12345, 10'b0000001000);
        wait_done(4'd3, 3'd4, 1'b0);

        // Tie between classes 2 and 7, with backpressure and start pulsed during DECIDE.
        begin_inference();
        apply_stimulus(20'h00000, 10'b0010000100);
        bp_ok = 1'b1;
        bus_if.spk_2 = 10'h3FF;
        for (int i = 0; i < 50; i++) begin
            if (bus_if.fc_addra_valid !== 1'b0 || bus_if.spk1_ready !== 1'b1) bp_ok = 1'b0;
            tick();
        end
        check_output("backpressure", {31'b0, bp_ok}, 32'd1);
        apply_stimulus(20'hFFFFF, 10'b0010000100);
        apply_stimulus(20'h00010, 10'b0010000100);
        apply_stimulus(20'h40000, 10'b0000000001);
        wait_done(4'd2, 3'd3, 1'b1);

        // Reset during FEED cycle 10 aborts; a fresh inference then completes.
        begin_inference();
        bus_if.spk1_vec   = 20'hFFFFF;
        bus_if.spk1_valid = 1'b1;
        tick();
        bus_if.spk1_valid = 1'b0;
        for (int c = 1; c < 10; c++) tick();
        check_output("mid_feed_addra", {31'b0, bus_if.fc_addra_valid}, 32'd1);
        reset = 1'b1;
        tick();
        check_output("abort_busy", {31'b0, busy}, 32'd0);
        check_output("abort_addra", {31'b0, bus_if.fc_addra_valid}, 32'd0);
        check_output("abort_fc_bit", {31'b0, bus_if.input_fc_array}, 32'd0);
        check_output("abort_ready", {31'b0, bus_if.spk1_ready}, 32'd0);
        check_output("abort_done", {31'b0, done}, 32'd0);
        check_output("abort_class_id", {28'b0, class_id}, 32'd0);
        check_output("abort_class_cnt", {29'b0, class_cnt}, 32'd0);
        reset = 1'b0;
        tick();
        begin_inference();
        apply_stimulus(20'h0000F, 10'b1000100000);
        apply_stimulus(20'hF0000, 10'b0000100000);
        apply_stimulus(20'h00C30, 10'b1000000000);
        apply_stimulus(20'h55555, 10'b0000100000);
        wait_done(4'd5, 3'd3, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
